dual_issue_responder: RTL and testbench

- Responder end of the scheduler's dual-lane issue handshake. The scheduler drives per-lane valid and operation fields; this block returns ack1/ack2 and produces register-file write-back for each lane.
- Single-cycle ALU ops are accepted immediately.
- MUL ops run on a per-lane iterative shift-add multiplier and are acked only when the product is ready.
- Sits between scheduling_assistant and register_file, replacing the constant acks and the direct ALU-to-regfile write path.

---
 rtl/dual_issue_responder.sv | 227 ++++++++++++++++++++++
 tb/tb_dual_issue_responder.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/dual_issue_responder.sv
// dual_issue_responder
//   Responder side of the scheduler's dual-lane issue handshake. ALU ops are
//   acked on presentation. MUL ops run on a per-lane iterative shift-add
//   multiplier and are acked once the product is ready. Each lane has its own
//   registered write-back port into the register file.
//
//   Optional feature macro: ISSUE_PERF_CNT_EN
//     defined   : retired1 / retired2 / stall_cycles performance counters
//     undefined : those ports are tied to zero and no counter flops exist
//
//   Lane FSM (identical per lane)
//   state | meaning
//   IDLE  | accepting; ALU ops acked immediately, MUL ops start here
//   BUSY  | iterating the shift-add multiplier, ack held low
//   DONE  | product ready, ack follows valid until the transfer
module dual_issue_responder #(
  parameter int MUL_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid1,
  input  logic        mul1,
  input  logic [4:0]  rd1,
  input  logic [31:0] alu_res1,
  input  logic [31:0] op_a1,
  input  logic [31:0] op_b1,
  output logic        ack1,
  input  logic        valid2,
  input  logic        mul2,
  input  logic [4:0]  rd2,
  input  logic [31:0] alu_res2,
  input  logic [31:0] op_a2,
  input  logic [31:0] op_b2,
  output logic        ack2,
  output logic        reg_write,
  output logic [4:0]  regd,
  output logic [31:0] write_data,
  output logic        reg_write2,
  output logic [4:0]  regd2,
  output logic [31:0] write_data2,
  output logic [31:0] retired1,
  output logic [31:0] retired2,
  output logic [31:0] stall_cycles
);

  // Bits of the multiplier consumed per iteration.
  localparam int unsigned CHUNK      = 32 / MUL_CYCLES;
  localparam logic [31:0] CHUNK_MASK = 32'hFFFF_FFFF >> (32 - CHUNK);
  localparam logic [4:0]  CNT_INIT   = 5'(MUL_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lane_state_t;

  // Per-lane views of the input ports; index 0 is lane 1, index 1 is lane 2.
  logic        valid_v [2];
  logic        mul_v   [2];
  logic [4:0]  rd_v    [2];
  logic [31:0] alu_v   [2];
  logic [31:0] op_a_v  [2];
  logic [31:0] op_b_v  [2];

  assign valid_v[0] = valid1;
  assign valid_v[1] = valid2;
  assign mul_v[0]   = mul1;
  assign mul_v[1]   = mul2;
  assign rd_v[0]    = rd1;
  assign rd_v[1]    = rd2;
  assign alu_v[0]   = alu_res1;
  assign alu_v[1]   = alu_res2;
  assign op_a_v[0]  = op_a1;
  assign op_a_v[1]  = op_a2;
  assign op_b_v[0]  = op_b1;
  assign op_b_v[1]  = op_b2;

  lane_state_t state_q [2];
  lane_state_t state_d [2];

  // Multiplier working registers: a is shifted up and b shifted down by one
  // chunk per iteration, so each step only looks at the low chunk of b.
  logic [31:0] mul_a_q [2];
  logic [31:0] mul_b_q [2];
  logic [31:0] acc_q   [2];
  logic [4:0]  mul_rd_q[2];
  logic [4:0]  cnt_q   [2];

  logic        ack_v   [2];
  logic [4:0]  sel_rd  [2];
  logic [31:0] sel_data[2];
  logic        we      [2];

  // State register for both lanes.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) state_q[i] <= IDLE;
      else     state_q[i] <= state_d[i];
    end
  end

  // Next-state logic; dropping valid in BUSY or DONE aborts the MUL.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        IDLE: if (valid_v[i] && mul_v[i]) state_d[i] = BUSY;
        BUSY: begin
          if (!valid_v[i])          state_d[i] = IDLE;
          else if (cnt_q[i] == '0)  state_d[i] = DONE;
        end
        DONE:    state_d[i] = IDLE;
        default: state_d[i] = IDLE;
      endcase
    end
  end

  // Output logic: acks, write-back source select and write enables.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      ack_v[i]    = 1'b0;
      sel_rd[i]   = rd_v[i];
      sel_data[i] = alu_v[i];
      case (state_q[i])
        IDLE: ack_v[i] = valid_v[i] && !mul_v[i];
        DONE: begin
          ack_v[i]    = valid_v[i];
          sel_rd[i]   = mul_rd_q[i];
          sel_data[i] = acc_q[i];
        end
        default: ack_v[i] = 1'b0;
      endcase
    end
    // x0 is never written; on a same-rd collision the younger lane 2 wins.
    we[1] = ack_v[1] && (sel_rd[1] != 5'd0);
    we[0] = ack_v[0] && (sel_rd[0] != 5'd0) &&
            !(ack_v[1] && (sel_rd[1] == sel_rd[0]));
  end

  assign ack1 = ack_v[0];
  assign ack2 = ack_v[1];

  // Multiplier datapath: latch operands on MUL start, one chunk per BUSY cycle.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        mul_a_q[i]  <= '0;
        mul_b_q[i]  <= '0;
        acc_q[i]    <= '0;
        mul_rd_q[i] <= '0;
        cnt_q[i]    <= '0;
      end else if (state_q[i] == IDLE && valid_v[i] && mul_v[i]) begin
        mul_a_q[i]  <= op_a_v[i];
        mul_b_q[i]  <= op_b_v[i];
        acc_q[i]    <= '0;
        mul_rd_q[i] <= rd_v[i];
        cnt_q[i]    <= CNT_INIT;
      end else if (state_q[i] == BUSY && valid_v[i]) begin
        acc_q[i]   <= acc_q[i] + mul_a_q[i] * (mul_b_q[i] & CHUNK_MASK);
        mul_a_q[i] <= mul_a_q[i] << CHUNK;
        mul_b_q[i] <= mul_b_q[i] >> CHUNK;
        if (cnt_q[i] != '0) cnt_q[i] <= cnt_q[i] - 5'd1;
      end
    end
  end

  // Registered write-back; address and data only move with the strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write   <= 1'b0;
      regd        <= '0;
      write_data  <= '0;
      reg_write2  <= 1'b0;
      regd2       <= '0;
      write_data2 <= '0;
    end else begin
      reg_write  <= we[0];
      reg_write2 <= we[1];
      if (we[0]) begin
        regd       <= sel_rd[0];
        write_data <= sel_data[0];
      end
      if (we[1]) begin
        regd2       <= sel_rd[1];
        write_data2 <= sel_data[1];
      end
    end
  end

`ifdef ISSUE_PERF_CNT_EN
  logic [31:0] retired1_q;
  logic [31:0] retired2_q;
  logic [31:0] stall_q;
  logic        stall_now;

  // A lane stalls the pipe while multiplying or while its product waits on valid.
  always_comb begin
    stall_now = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (state_q[i] == BUSY || (state_q[i] == DONE && !valid_v[i]))
        stall_now = 1'b1;
    end
  end

  // Retire and stall counters, free-running with natural wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      retired1_q <= '0;
      retired2_q <= '0;
      stall_q    <= '0;
    end else begin
      if (ack_v[0]) retired1_q <= retired1_q + 32'd1;
      if (ack_v[1]) retired2_q <= retired2_q + 32'd1;
      if (stall_now) stall_q   <= stall_q + 32'd1;
    end
  end

  assign retired1     = retired1_q;
  assign retired2     = retired2_q;
  assign stall_cycles = stall_q;
`else
  assign retired1     = '0;
  assign retired2     = '0;
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_dual_issue_responder.sv
// Directed bench for dual_issue_responder (MUL_CYCLES = 4): ALU vector table
// plus hand-written MUL, overflow, abort and reset sequences.
module tb_dual_issue_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid1, mul1, valid2, mul2;
  logic [4:0]  rd1, rd2;
  logic [31:0] alu_res1, op_a1, op_b1, alu_res2, op_a2, op_b2;
  logic        ack1, ack2, reg_write, reg_write2;
  logic [4:0]  regd, regd2;
  logic [31:0] write_data, write_data2, retired1, retired2, stall_cycles;

  int tests  = 0;
  int errors = 0;

  dual_issue_responder #(.MUL_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .valid1(valid1), .mul1(mul1), .rd1(rd1), .alu_res1(alu_res1),
    .op_a1(op_a1), .op_b1(op_b1), .ack1(ack1),
    .valid2(valid2), .mul2(mul2), .rd2(rd2), .alu_res2(alu_res2),
    .op_a2(op_a2), .op_b2(op_b2), .ack2(ack2),
    .reg_write(reg_write), .regd(regd), .write_data(write_data),
    .reg_write2(reg_write2), .regd2(regd2), .write_data2(write_data2),
    .retired1(retired1), .retired2(retired2), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v1;
    logic [4:0]  rd1;
    logic [31:0] alu1;
    logic        v2;
    logic [4:0]  rd2;
    logic [31:0] alu2;
    logic        ack1;
    logic        ack2;
    logic        rw1;
    logic        rw2;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4:0]  last_rd1, last_rd2;
    logic [31:0] last_wd1, last_wd2;
    logic        seen;
    int          n;

    // ALU-only vectors; expected write-back is observed one edge later.
    vecs[0] = '{1'b1, 5'd5, 32'h0000_00AA, 1'b0, 5'd0,  32'h0,          1'b1, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 5'd5, 32'h0000_00AA, 1'b0, 5'd0,  32'h0,          1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 5'd5, 32'h0000_00AA, 1'b0, 5'd0,  32'h0,          1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 5'd9, 32'h0000_0011, 1'b1, 5'd9,  32'h0000_0022,  1'b1, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 5'd0, 32'h0000_0033, 1'b0, 5'd0,  32'h0,          1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 5'd3, 32'h0000_0044, 1'b1, 5'd4,  32'h0000_0055,  1'b1, 1'b1, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 5'd7, 32'h0000_0099, 1'b1, 5'd0,  32'h0000_0066,  1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 5'd8, 32'h0000_0012, 1'b0, 5'd8,  32'h0000_0034,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 5'd0, 32'h0,         1'b1, 5'd31, 32'hDEAD_BEEF,  1'b0, 1'b1, 1'b0, 1'b1};

    rst = 1'b1;
    valid1 = 1'b0; mul1 = 1'b0; rd1 = '0; alu_res1 = '0; op_a1 = '0; op_b1 = '0;
    valid2 = 1'b0; mul2 = 1'b0; rd2 = '0; alu_res2 = '0; op_a2 = '0; op_b2 = '0;
    step();
    step();
    rst = 1'b0;
    step();

    // Reset in the middle of a lane-1 MUL.
    valid1 = 1'b1; mul1 = 1'b1; rd1 = 5'd6; op_a1 = 32'd3; op_b1 = 32'd7;
    step();
    step();
    check("busy_no_ack", {31'd0, ack1}, 32'd0);
    rst = 1'b1; valid1 = 1'b0; mul1 = 1'b0;
    step();
    step();
    check("rst_ack1", {31'd0, ack1}, 32'd0);
    check("rst_ack2", {31'd0, ack2}, 32'd0);
    check("rst_outputs", {30'd0, reg_write, reg_write2}, 32'd0);
    check("rst_regd", {22'd0, regd, regd2}, 32'd0);
    check("rst_wd", write_data, 32'd0);
    check("rst_wd2", write_data2, 32'd0);
    check("rst_counters", retired1 | retired2 | stall_cycles, 32'd0);
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      seen = seen | reg_write | ack1;
    end
    check("post_rst_no_wb", {31'd0, seen}, 32'd0);

    last_rd1 = '0; last_wd1 = '0; last_rd2 = '0; last_wd2 = '0;
    for (int i = 0; i < 9; i++) begin
      valid1 = vecs[i].v1; rd1 = vecs[i].rd1; alu_res1 = vecs[i].alu1;
      valid2 = vecs[i].v2; rd2 = vecs[i].rd2; alu_res2 = vecs[i].alu2;
      #1;
      check($sformatf("vec%0d_ack1", i), {31'd0, ack1}, {31'd0, vecs[i].ack1});
      check($sformatf("vec%0d_ack2", i), {31'd0, ack2}, {31'd0, vecs[i].ack2});
      step();
      if (vecs[i].rw1) begin last_rd1 = vecs[i].rd1; last_wd1 = vecs[i].alu1; end
      if (vecs[i].rw2) begin last_rd2 = vecs[i].rd2; last_wd2 = vecs[i].alu2; end
      check($sformatf("vec%0d_rw1", i), {31'd0, reg_write}, {31'd0, vecs[i].rw1});
      check($sformatf("vec%0d_rw2", i), {31'd0, reg_write2}, {31'd0, vecs[i].rw2});
      check($sformatf("vec%0d_regd", i), {27'd0, regd}, {27'd0, last_rd1});
      check($sformatf("vec%0d_wd", i), write_data, last_wd1);
      check($sformatf("vec%0d_regd2", i), {27'd0, regd2}, {27'd0, last_rd2});
      check($sformatf("vec%0d_wd2", i), write_data2, last_wd2);
    end
    valid1 = 1'b0; valid2 = 1'b0;
    step();
    check("idle_rw", {30'd0, reg_write, reg_write2}, 32'd0);

    // Lane-2 MUL latency and product.
    valid2 = 1'b1; mul2 = 1'b1; rd2 = 5'd7; op_a2 = 32'h0001_0003; op_b2 = 32'h0000_0005;
    n = 0;
    #1;
    while (!ack2 && n < 20) begin
      step();
      n++;
    end
    check("mul2_latency", n, 32'd5);
    step();
    valid2 = 1'b0; mul2 = 1'b0;
    check("mul2_rw", {31'd0, reg_write2}, 32'd1);
    check("mul2_regd", {27'd0, regd2}, 32'd7);
    check("mul2_wd", write_data2, 32'h0005_000F);
    step();
    check("mul2_strobe_1cyc", {31'd0, reg_write2}, 32'd0);
    check("mul2_hold_wd", write_data2, 32'h0005_000F);

    // Lane-1 MUL with wrapping product.
    valid1 = 1'b1; mul1 = 1'b1; rd1 = 5'd12; op_a1 = 32'hFFFF_FFFF; op_b1 = 32'hFFFF_FFFF;
    n = 0;
    #1;
    while (!ack1 && n < 20) begin
      step();
      n++;
    end
    check("mul1_latency", n, 32'd5);
    step();
    valid1 = 1'b0; mul1 = 1'b0;
    check("ovf_rw", {31'd0, reg_write}, 32'd1);
    check("ovf_regd", {27'd0, regd}, 32'd12);
    check("ovf_wd", write_data, 32'h0000_0001);

    // Abort a lane-1 MUL while BUSY.
    valid1 = 1'b1; mul1 = 1'b1; rd1 = 5'd13; op_a1 = 32'd9; op_b1 = 32'd9;
    step();
    step();
    check("abort_busy_ack", {31'd0, ack1}, 32'd0);
    valid1 = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      seen = seen | reg_write | ack1;
    end
    check("abort_no_wb", {31'd0, seen}, 32'd0);
    mul1 = 1'b0; valid1 = 1'b1; rd1 = 5'd2; alu_res1 = 32'h0000_0077;
    #1;
    check("abort_idle_ack", {31'd0, ack1}, 32'd1);
    step();
    valid1 = 1'b0;
    check("abort_alu_rw", {31'd0, reg_write}, 32'd1);
    check("abort_alu_wd", write_data, 32'h0000_0077);
    step();

`ifdef ISSUE_PERF_CNT_EN
    // Lane-1 acks: 6 table, 1 MUL, 1 ALU. Lane-2: 4 table, 1 MUL.
    // Stall: 4 + 4 BUSY cycles for the two MULs, 2 for the aborted one.
    check("perf_retired1", retired1, 32'd8);
    check("perf_retired2", retired2, 32'd5);
    check("perf_stall", stall_cycles, 32'd10);
`else
    check("perf_off_tied", retired1 | retired2 | stall_cycles, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
